// File: rtl/multi_operand_sum_ctrl_if.sv
// multi_operand_sum_ctrl_if
// Groups the command, operand and result handshakes of the multi-operand
// sum controller into one bundle.
//   start, op_count        : run command from the operand source
//   in_valid/in_ready      : operand handshake, in_data carries the operand
//   out_valid/out_ready    : result handshake, sum carries the result
//   busy, ops_left         : status toward the operand source / display
// Modports: slave = the controller, master = source/consumer side.
interface multi_operand_sum_ctrl_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 3,
  parameter int ACC_W = 7
) ();
  logic             start;
  logic [CNT_W-1:0] op_count;
  logic             in_valid;
  logic [OP_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             busy;
  logic [CNT_W-1:0] ops_left;

  modport slave (
    input  start, op_count, in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, busy, ops_left
  );

  modport master (
    output start, op_count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, busy, ops_left
  );
endinterface

// File: rtl/multi_operand_sum_ctrl.sv
// multi_operand_sum_ctrl
// Sums a run of OP_W-bit operands through one shared adder, one operand
// per accepted cycle, then offers the result over a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, discards any run in progress
//   ctrl : multi_operand_sum_ctrl_if.slave (command, operand and result
//          handshakes plus busy/ops_left status)
module multi_operand_sum_ctrl #(
  parameter int OP_W    = 4,
  parameter int MAX_OPS = 5,
  parameter int CNT_W   = 3,
  parameter int ACC_W   = 7
) (
  input  logic clk,
  input  logic rst,
  multi_operand_sum_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0] left, left_next;
  logic [CNT_W-1:0] clamped;

  // Requests above MAX_OPS are clamped rather than rejected.
  assign clamped = (ctrl.op_count > MAX_CNT) ? MAX_CNT : ctrl.op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      left  <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      left  <= left_next;
    end
  end

  // acc is not cleared on the DONE->IDLE handoff so sum stays readable
  // until the next start.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    left_next  = left;
    case (state)
      IDLE: begin
        if (ctrl.start) begin
          acc_next   = '0;
          left_next  = clamped;
          state_next = (clamped != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        // in_ready is implied by being in LOAD.
        if (ctrl.in_valid) begin
          acc_next  = acc + ACC_W'(ctrl.in_data);
          left_next = left - 1'b1;
          if (left == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        if (ctrl.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl.in_ready  = 1'b0;
    ctrl.out_valid = 1'b0;
    ctrl.busy      = 1'b1;
    case (state)
      IDLE:    ctrl.busy      = 1'b0;
      LOAD:    ctrl.in_ready  = 1'b1;
      DONE:    ctrl.out_valid = 1'b1;
      default: ctrl.busy      = 1'b1;
    endcase
  end

  assign ctrl.sum      = acc;
  assign ctrl.ops_left = left;

endmodule

// File: tb/tb_multi_operand_sum_ctrl.sv
// tb_multi_operand_sum_ctrl
// Drives directed and randomized runs into multi_operand_sum_ctrl and
// compares every observed handshake/status output against expectations
// computed from the run description (clamped count, operand list sum).
module tb_multi_operand_sum_ctrl;

  localparam int OP_W    = 4;
  localparam int MAX_OPS = 5;
  localparam int CNT_W   = 3;
  localparam int ACC_W   = 7;

  logic clk;
  logic rst;

  multi_operand_sum_ctrl_if #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

  multi_operand_sum_ctrl #(
    .OP_W(OP_W), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int op_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the stimulus has no open-ended waits, this only guards
  // against a simulator-level stall.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete run: command, operands from op_q (with gap idle cycles
  // before each), bp cycles of result backpressure, then handoff.
  // poke pulses an ignored start in LOAD and DONE.
  task automatic applyStimulus(input int count, input int gap, input int bp,
                               input bit poke);
    int n;
    int exp_sum;
    int left;
    n = (count > MAX_OPS) ? MAX_OPS : count;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += op_q[i];
    exp_sum = exp_sum % (1 << ACC_W);

    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_out_valid", bus.out_valid, 0);
    checkOutput("idle_in_ready", bus.in_ready, 0);

    bus.start    = 1'b1;
    bus.op_count = CNT_W'(count);
    tick();
    bus.start    = 1'b0;
    left = n;

    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        checkOutput("gap_in_ready", bus.in_ready, 1);
        checkOutput("gap_ops_left", bus.ops_left, left);
        checkOutput("gap_busy", bus.busy, 1);
        checkOutput("gap_out_valid", bus.out_valid, 0);
        tick();
      end
      checkOutput("load_in_ready", bus.in_ready, 1);
      checkOutput("load_ops_left", bus.ops_left, left);
      checkOutput("load_busy", bus.busy, 1);
      checkOutput("load_out_valid", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = OP_W'(op_q[i]);
      if (poke && i == 0) begin
        bus.start    = 1'b1;
        bus.op_count = CNT_W'(1);
      end
      tick();
      bus.start = 1'b0;
      left--;
    end
    bus.in_valid = 1'b0;

    checkOutput("done_out_valid", bus.out_valid, 1);
    checkOutput("done_sum", bus.sum, exp_sum);
    checkOutput("done_in_ready", bus.in_ready, 0);
    checkOutput("done_ops_left", bus.ops_left, 0);
    checkOutput("done_busy", bus.busy, 1);

    for (int b = 0; b < bp; b++) begin
      bus.out_ready = 1'b0;
      if (poke && b == 0) begin
        bus.start    = 1'b1;
        bus.op_count = CNT_W'(1);
      end
      tick();
      bus.start = 1'b0;
      checkOutput("hold_out_valid", bus.out_valid, 1);
      checkOutput("hold_sum", bus.sum, exp_sum);
      checkOutput("hold_busy", bus.busy, 1);
      checkOutput("hold_in_ready", bus.in_ready, 0);
    end

    bus.out_ready = 1'b1;
    if (poke) begin
      bus.start    = 1'b1;
      bus.op_count = CNT_W'(1);
    end
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput("handoff_out_valid", bus.out_valid, 0);
    checkOutput("handoff_busy", bus.busy, 0);
    checkOutput("handoff_sum_kept", bus.sum, exp_sum);
    checkOutput("handoff_ops_left", bus.ops_left, 0);
    checkOutput("handoff_in_ready", bus.in_ready, 0);

    tick();
    checkOutput("no_extra_run_busy", bus.busy, 0);
    checkOutput("no_extra_run_sum", bus.sum, exp_sum);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.op_count  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_sum", bus.sum, 0);
    checkOutput("reset_ops_left", bus.ops_left, 0);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_busy", bus.busy, 0);
    tick();

    $display("[TB] single run 3+5+15");
    op_q = '{3, 5, 15};
    applyStimulus(3, 0, 0, 1'b0);

    $display("[TB] max run 5x15");
    op_q = '{15, 15, 15, 15, 15};
    applyStimulus(5, 0, 0, 1'b0);

    $display("[TB] clamp 7 to 5 with gaps");
    op_q = '{1, 1, 1, 1, 1, 1, 1};
    applyStimulus(7, 2, 0, 1'b0);

    $display("[TB] zero operands with backpressure");
    op_q.delete();
    applyStimulus(0, 0, 4, 1'b0);

    $display("[TB] reset mid-run");
    bus.start    = 1'b1;
    bus.op_count = CNT_W'(4);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = OP_W'(9);
    tick();
    bus.in_data  = OP_W'(6);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("midrun_ops_left", bus.ops_left, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_sum", bus.sum, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_ops_left", bus.ops_left, 0);
    op_q = '{2, 2};
    applyStimulus(2, 0, 0, 1'b0);

    $display("[TB] ignored start in LOAD and DONE");
    op_q = '{7, 4, 9};
    applyStimulus(3, 1, 2, 1'b1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 20; r++) begin
      int cnt;
      op_q.delete();
      cnt = int'($urandom_range(0, 7));
      for (int k = 0; k < 7; k++) op_q.push_back(int'($urandom_range(0, 15)));
      applyStimulus(cnt, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_operand_sum_ctrl.md
Name: multi_operand_sum_ctrl

Overview:
Sequencing controller that sums a run of 4-bit operands. All operands enter through a single shared operand bus, and the block reuses one adder stage across cycles instead of a tree of fixed adders. A start command sets the operand count. Operands are accepted over a valid/ready handshake and accumulated one per cycle. The final sum is presented over a valid/ready output handshake. It sits between the push-button/switch operand source and the result display logic.

Parameters:
OP_W, 4, operand width in bits
MAX_OPS, 5, maximum operands per run; larger requests are clamped to this
CNT_W, 3, width of op_count; must satisfy 2^CNT_W > MAX_OPS
ACC_W, 7, accumulator/sum width; sized so MAX_OPS*(2^OP_W-1) never overflows (5*15=75 < 128)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
op_count  input  CNT_W  operands in this run; sampled with start
in_valid  input  1  operand on in_data is valid
in_data  input  OP_W  operand value, zero-extended to ACC_W before the add
in_ready  output  1  block accepts an operand this cycle
out_valid  output  1  sum is valid
out_ready  input  1  consumer accepts the sum
sum  output  ACC_W  accumulated result
busy  output  1  high in any state other than IDLE
ops_left  output  CNT_W  operands still to be accepted in this run

Behaviour:
- Reset: on the rst=1 clock edge, go to IDLE. Set sum=0, ops_left=0, in_ready=0, out_valid=0, busy=0. Reset wins over every other input on the same edge, including mid-run: any partial accumulation is discarded.
- States: IDLE, LOAD, DONE. in_ready=1 only in LOAD. out_valid=1 only in DONE.
- IDLE with start=1:
  - Clear the accumulator to 0.
  - Set ops_left=min(op_count, MAX_OPS).
  - Next state is LOAD if that value is nonzero. If op_count=0, next state is DONE with sum=0.
  - start=0 keeps the block in IDLE.
- start is ignored outside IDLE. No restart or abort path exists except rst.
- LOAD, operand accept:
  - An operand is accepted on a cycle with in_valid=1 and in_ready=1.
  - On that edge, the accumulator becomes accumulator + zero_extend(in_data), and ops_left decrements.
  - One accept per cycle maximum. Back-to-back accepts on consecutive cycles are required (no bubble).
- LOAD, idle cycles: when in_valid=0, the accumulator and ops_left hold. Gaps of any length are legal.
- LOAD, last operand: the edge that accepts the operand when ops_left=1 moves the block to DONE. in_ready drops the following cycle.
- Latency: sum is visible with out_valid=1 in the cycle immediately after the last accept.
- DONE:
  - sum and out_valid hold stable while out_ready=0 (no timeout).
  - On the edge with out_valid=1 and out_ready=1, go to IDLE. out_valid drops next cycle. sum keeps its last value until the next start.
- Simultaneous start and out_ready in DONE: start is ignored. A new run needs start asserted in IDLE, at least one cycle after the handoff.
- Arithmetic: unsigned addition modulo 2^ACC_W. With the default parameters, overflow cannot occur. No carry output is produced.
- ops_left is 0 in IDLE and DONE.

Test Plan:
- Single run: start with op_count=3, then operands 3, 5, 15 on consecutive cycles with out_ready=1 → in_ready high for exactly 3 cycles; out_valid for 1 cycle with sum=23; then IDLE.
- Max run: op_count=5, five operands of 15 → sum=75 (7'b1001011), no overflow; busy high from the cycle after start through the handoff.
- Clamp and gaps: op_count=7, five operands of 1 with in_valid low for 2 cycles between each → exactly 5 accepts; ops_left steps 5,4,3,2,1,0; sum=5.
- Zero operands plus backpressure: op_count=0, out_ready held low for 4 cycles → in_ready never asserted; out_valid=1 and sum=0 held stable for 4 cycles; IDLE the cycle after out_ready rises.
- Reset mid-run: op_count=4, accept 9 and 6, assert rst for 1 cycle → next cycle IDLE with sum=0, busy=0, in_ready=0. A following run with op_count=2 and operands 2, 2 gives sum=4.
- Ignored start: pulse start during LOAD and during DONE with op_count=1 → ops_left and sum unaffected; no extra run occurs after the handoff.
